// File: rtl/chroma_demod_if.sv
// Chroma demodulator stream interface: separated chroma in, filtered U/V and lock status out.
interface chroma_demod_if #(
    parameter int unsigned DATA_WIDTH = 12
);
    logic signed [DATA_WIDTH-1:0] chroma_in;
    logic                         in_valid;
    logic                         burst_gate;
    logic                         line_start;
    logic signed [DATA_WIDTH-1:0] u_out;
    logic signed [DATA_WIDTH-1:0] v_out;
    logic                         out_valid;
    logic                         locked;
    logic [1:0]                   phase_sel;

    modport master (
        output chroma_in, in_valid, burst_gate, line_start,
        input  u_out, v_out, out_valid, locked, phase_sel
    );

    modport slave (
        input  chroma_in, in_valid, burst_gate, line_start,
        output u_out, v_out, out_valid, locked, phase_sel
    );
endinterface

// File: rtl/chroma_demod.sv
// Quadrature chroma demodulator: burst quadrant lock, 4x-subcarrier demod, boxcar U/V filter.
// Optional colour killer (zero outputs while unlocked) enabled by defining CHROMA_DEMOD_KILL_EN.
module chroma_demod #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned AVG_LEN    = 8,
    parameter int unsigned BURST_MIN  = 16
) (
    input logic           clk,
    input logic           rst_n,
    chroma_demod_if.slave bus
);
    localparam int unsigned AVG_LOG2 = $clog2(AVG_LEN);
    localparam int unsigned SUM_W    = DATA_WIDTH + AVG_LOG2 + 1;
    localparam int unsigned ACC_W    = DATA_WIDTH + 8;

    localparam logic signed [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [SUM_W-1:0]      SUM_MAX = {{(SUM_W-DATA_WIDTH){1'b0}}, MAX_VAL};
    localparam logic signed [SUM_W-1:0]      SUM_MIN = ~SUM_MAX;

    typedef enum logic [1:0] {StIdle, StAccum, StDecide} state_e;

    // Half the products are zero, so the boxcar gain is AVG_LEN/2, not AVG_LEN.
    function automatic logic signed [DATA_WIDTH-1:0] sat_shift(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] sh;
        sh = s >>> (AVG_LOG2 - 1);
        if (sh > SUM_MAX) return MAX_VAL;
        if (sh < SUM_MIN) return MIN_VAL;
        return sh[DATA_WIDTH-1:0];
    endfunction

    logic signed [DATA_WIDTH-1:0] x, x_neg;
    logic signed [ACC_W-1:0]      x_acc;
    logic [1:0]                   ph_q, eff;
    logic [1:0]                   phase_sel_q, phase_sel_d;
    logic                         locked_q, locked_d;
    logic                         kill;

    assign x     = bus.chroma_in;
    assign x_neg = (x == MIN_VAL) ? MAX_VAL : -x;
    assign x_acc = {{(ACC_W-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    assign eff   = ph_q + phase_sel_q;

    // Stage 1: demodulated products
    logic signed [DATA_WIDTH-1:0] u_prod_d, v_prod_d, u_prod_q, v_prod_q;
    logic                         p_valid_q;

    always_comb begin
        u_prod_d = '0;
        v_prod_d = '0;
        unique case (eff)
            2'd0: u_prod_d = x;
            2'd1: v_prod_d = x;
            2'd2: u_prod_d = x_neg;
            2'd3: v_prod_d = x_neg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q      <= '0;
            u_prod_q  <= '0;
            v_prod_q  <= '0;
            p_valid_q <= 1'b0;
        end else begin
            p_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                ph_q     <= ph_q + 2'd1;
                u_prod_q <= u_prod_d;
                v_prod_q <= v_prod_d;
            end
        end
    end

    // Stage 2: boxcar running sums over a circular history
    logic signed [DATA_WIDTH-1:0] u_hist_q [AVG_LEN];
    logic signed [DATA_WIDTH-1:0] v_hist_q [AVG_LEN];
    logic [AVG_LOG2-1:0]          hist_ptr_q;
    logic signed [SUM_W-1:0]      u_sum_q, v_sum_q, u_sum_d, v_sum_d;
    logic signed [SUM_W-1:0]      u_prod_ext, v_prod_ext, u_old_ext, v_old_ext;
    logic signed [DATA_WIDTH-1:0] u_out_q, v_out_q;
    logic                         out_valid_q;

    assign u_prod_ext = {{(SUM_W-DATA_WIDTH){u_prod_q[DATA_WIDTH-1]}}, u_prod_q};
    assign v_prod_ext = {{(SUM_W-DATA_WIDTH){v_prod_q[DATA_WIDTH-1]}}, v_prod_q};
    assign u_old_ext  = {{(SUM_W-DATA_WIDTH){u_hist_q[hist_ptr_q][DATA_WIDTH-1]}},
                         u_hist_q[hist_ptr_q]};
    assign v_old_ext  = {{(SUM_W-DATA_WIDTH){v_hist_q[hist_ptr_q][DATA_WIDTH-1]}},
                         v_hist_q[hist_ptr_q]};
    assign u_sum_d    = u_sum_q + u_prod_ext - u_old_ext;
    assign v_sum_d    = v_sum_q + v_prod_ext - v_old_ext;

`ifdef CHROMA_DEMOD_KILL_EN
    assign kill = ~locked_q;
`else
    assign kill = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < AVG_LEN; i++) begin
                u_hist_q[i] <= '0;
                v_hist_q[i] <= '0;
            end
            hist_ptr_q  <= '0;
            u_sum_q     <= '0;
            v_sum_q     <= '0;
            u_out_q     <= '0;
            v_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= p_valid_q;
            if (p_valid_q) begin
                u_hist_q[hist_ptr_q] <= u_prod_q;
                v_hist_q[hist_ptr_q] <= v_prod_q;
                hist_ptr_q           <= hist_ptr_q + 1'b1;
                u_sum_q              <= u_sum_d;
                v_sum_q              <= v_sum_d;
                u_out_q              <= kill ? '0 : sat_shift(u_sum_d);
                v_out_q              <= kill ? '0 : sat_shift(v_sum_d);
            end
        end
    end

    // Burst lock FSM
    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] q_acc_q [4];
    logic signed [ACC_W-1:0] q_acc_d [4];
    logic [7:0]              cnt_q, cnt_d;
    logic [1:0]              k_max;

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        k_max = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (q_acc_q[i] > q_acc_q[k_max]) k_max = 2'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        q_acc_d     = q_acc_q;
        cnt_d       = cnt_q;
        phase_sel_d = phase_sel_q;
        locked_d    = locked_q;
        unique case (state_q)
            StIdle: begin
                if (bus.burst_gate && bus.in_valid) begin
                    state_d = StAccum;
                    for (int i = 0; i < 4; i++) q_acc_d[i] = '0;
                    q_acc_d[ph_q] = x_acc;
                    cnt_d         = 8'd1;
                end
            end
            StAccum: begin
                if (bus.line_start) begin
                    state_d = StIdle;
                end else if (!bus.burst_gate || cnt_q == 8'hFF) begin
                    state_d = StDecide;
                end else if (bus.in_valid) begin
                    q_acc_d[ph_q] = q_acc_q[ph_q] + x_acc;
                    cnt_d         = cnt_q + 8'd1;
                end
            end
            StDecide: begin
                state_d = StIdle;
                if (32'(cnt_q) >= BURST_MIN) begin
                    phase_sel_d = 2'd2 - k_max;
                    locked_d    = 1'b1;
                end else begin
                    locked_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            for (int i = 0; i < 4; i++) q_acc_q[i] <= '0;
            cnt_q       <= '0;
            phase_sel_q <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_acc_q     <= q_acc_d;
            cnt_q       <= cnt_d;
            phase_sel_q <= phase_sel_d;
            locked_q    <= locked_d;
        end
    end

    assign bus.u_out     = u_out_q;
    assign bus.v_out     = v_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.locked    = locked_q;
    assign bus.phase_sel = phase_sel_q;
endmodule

// File: doc/chroma_demod.md
# chroma_demod

Quadrature chroma demodulator sitting directly downstream of the Y/C separator. It consumes the separated signed chroma stream, sampled at 4× the colour subcarrier. It locks a quadrant phase offset to the colour burst and produces boxcar-filtered U and V baseband components for the colour-space converter.

## Interface
- DATA_WIDTH, 12, sample and output width (signed)
- AVG_LEN, 8, boxcar length in samples; power of two, ≥4
- BURST_MIN, 16, minimum valid burst samples for a lock decision
- clk  in  1  system clock
- rst_n  in  1  reset: one clock; asynchronous, active-low
- chroma_in  in  DATA_WIDTH  signed chroma sample from the Y/C separator
- in_valid  in  1  chroma_in qualifier
- burst_gate  in  1  high across the burst window
- line_start  in  1  one-cycle pulse at start of each line
- u_out  out  DATA_WIDTH  signed filtered U
- v_out  out  DATA_WIDTH  signed filtered V
- out_valid  out  1  u_out/v_out qualifier
- locked  out  1  last burst decision succeeded
- phase_sel  out  2  current quadrant offset

## Operation
- ph: 2-bit counter, +1 per in_valid sample, free-running; line_start does not reset it.
- eff = (ph + phase_sel) mod 4. Demodulation map:
  - 0: u=+x, v=0
  - 1: u=0, v=+x
  - 2: u=−x, v=0
  - 3: u=0, v=−x
- Negating −2^(DATA_WIDTH−1) saturates to 2^(DATA_WIDTH−1)−1.
- Boxcar: running sums of the last AVG_LEN demodulated u and v products, with history updated only on in_valid.
  - Output = sum >>> (log2(AVG_LEN)−1), arithmetic shift, because half the products are zero.
  - Output saturates to the DATA_WIDTH range.
  - History is zero after reset.
- Burst FSM, states IDLE, ACCUM, DECIDE:
  - IDLE → ACCUM on burst_gate&in_valid. This entry clears Q[0..3] and cnt, then accumulates that first sample.
  - ACCUM: each valid sample adds x to Q[ph] (width DATA_WIDTH+8) and increments cnt (8 bits).
  - ACCUM → DECIDE when burst_gate falls, or when cnt reaches 255 (forced).
  - ACCUM → IDLE on line_start, with no update (abort). A line_start in the same cycle as gate fall also aborts.
  - DECIDE, one cycle, then IDLE:
    - If cnt ≥ BURST_MIN: k = argmax Q (ties resolve to the lowest k), phase_sel ← (2−k) mod 4, locked ← 1. This places the burst on −U.
    - Else: locked ← 0, phase_sel held.
- The new phase_sel applies to samples accepted after the DECIDE cycle.
- A burst_gate high while in DECIDE is ignored until IDLE.
- Burst samples still pass through demodulation; the output is not blanked.

## Timing
- Reset values: u_out=0, v_out=0, out_valid=0, locked=0, phase_sel=0, FSM=IDLE, ph=0, Q/cnt/history=0.
- Latency: a sample accepted at cycle t appears in u_out/v_out with out_valid=1 at t+2.
  - Stage 1 registers the products; stage 2 registers the filtered result.
- out_valid mirrors in_valid delayed by 2 cycles. When it is low, u_out/v_out hold their last values.
- Back-to-back in_valid is supported every cycle; gaps are allowed.
- Reset mid-operation clears everything immediately, including an in-progress burst; no lock update occurs.
- phase_sel/locked change on the clock edge ending DECIDE, which is 1 cycle after the gate-fall sample.

## Configuration
- CHROMA_DEMOD_KILL_EN (colour killer).
  - Defined: while locked=0, u_out=v_out=0 at the output stage. The filter history keeps running, and out_valid is unaffected.
  - Undefined: outputs follow the filter regardless of locked.

## Test plan
Defaults apply unless stated; the "ph0…ph3" values are the per-ph input pattern, repeated.
- Constant chroma_in=100, phase_sel=0, 16 samples → u_out=v_out=0 after AVG_LEN samples; out_valid 2 cycles behind in_valid.
- Pattern ph0 +400, ph1 0, ph2 −400, ph3 0, phase_sel 0 → steady u_out=400, v_out=0; shift the pattern by one sample → u_out=0, v_out=∓400.
- Burst of 20 samples, pattern ph1 +300, ph3 −300, others 0 → phase_sel=1, locked=1 one cycle after gate fall. Then 12-sample burst → locked=0, phase_sel stays 1.
- Pattern ph0 −2048, ph2 +2047 → u_out saturates to −2048, with no wrap.
- line_start mid-burst after 18 samples → no change to phase_sel/locked. rst_n low for 1 cycle mid-burst → all outputs 0, FSM IDLE, next burst locks normally.
- With CHROMA_DEMOD_KILL_EN, before any burst: +400 pattern → u_out=0; after a valid burst, 400 appears.
